// File: rtl/corescore_uart_pkg.sv
// Shared types and helpers for the buffered UART emitter.
package corescore_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Cycles per UART bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/corescore_sync_fifo.sv
// Synchronous FIFO with registered storage; head word visible on o_rdata while non-empty.
// Latency: a write at edge N is readable after edge N (no bypass).
// Backpressure: writes ignored when full, reads ignored when empty.
module corescore_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_en, rd_en;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = i_wr && !o_full;
    rd_en    = i_rd && !o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/corescore_uart_emitter_buf.sv
// Buffered 8N1/8N2 UART transmitter with LED activity stretcher.
// Latency: byte accepted at edge N is popped at N+1; start bit drives the line after N+2.
// Backpressure: o_ready low in reset and while the FIFO holds DEPTH bytes.
module corescore_uart_emitter_buf
  import corescore_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 57_600,
  parameter int DEPTH       = 16,
  parameter int STOP_BITS   = 1,
  parameter int ACT_HOLD    = 2_500_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_uart_tx,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy,
  output logic                   o_activity
);

  localparam int DIV    = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int HOLD_W = $clog2(ACT_HOLD + 1);

  localparam logic [CNT_W-1:0]  DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_M1   = HOLD_W'(ACT_HOLD - 1);

  if (DIV < 2) begin : g_div_chk
    $error("corescore_uart_emitter_buf: bit period below 2 clocks");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("corescore_uart_emitter_buf: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("corescore_uart_emitter_buf: DEPTH must be a power of two >= 2");
  end
  if (ACT_HOLD < 1) begin : g_hold_chk
    $error("corescore_uart_emitter_buf: ACT_HOLD must be >= 1");
  end

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              hold_vld_q, hold_vld_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, pop, baud_done;

  assign o_ready    = !i_rst && !fifo_full;
  assign push       = i_valid && o_ready;
  assign o_uart_tx  = tx_q;
  assign o_busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign o_activity = (state_q != ST_IDLE) || hold_vld_q;

  corescore_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (push),
    .i_wdata (i_data),
    .i_rd    (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // Line level is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    pop        = 1'b0;
    hold_vld_d = hold_vld_q;
    hold_cnt_d = hold_cnt_q;
    baud_done  = (baud_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = DIV_M1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = DIV_M1;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_d  = DIV_M1;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        // bit_q counts stop bits here; the last one chains straight into the next frame.
        if (baud_done) begin
          baud_d = DIV_M1;
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_IDLE) begin
      hold_vld_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      hold_vld_d = 1'b1;
      hold_cnt_d = HOLD_M1;
    end else if (hold_vld_q) begin
      if (hold_cnt_q == '0) begin
        hold_vld_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      hold_vld_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      hold_vld_q <= hold_vld_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_corescore_uart_emitter_buf.sv
// Bench for corescore_uart_emitter_buf: three configurations sharing one clock,
// a frame-decoding line monitor with byte scoreboard, and waveform models.
module tb_corescore_uart_emitter_buf;

  localparam int DIV_A   = 10;
  localparam int FRAME_A = 100;
  localparam int HOLD_A  = 20;
  localparam int DIV_C   = 434;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic [2:0] level_a, level_b, level_c;
  logic       busy_a, busy_b, busy_c;
  logic       act_a, act_b, act_c;

  corescore_uart_emitter_buf #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DEPTH(4),
                               .STOP_BITS(1), .ACT_HOLD(HOLD_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a), .o_ready(ready_a),
    .o_uart_tx(tx_a), .o_level(level_a), .o_busy(busy_a), .o_activity(act_a));

  corescore_uart_emitter_buf #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DEPTH(4),
                               .STOP_BITS(2), .ACT_HOLD(HOLD_A)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b), .o_ready(ready_b),
    .o_uart_tx(tx_b), .o_level(level_b), .o_busy(busy_b), .o_activity(act_b));

  corescore_uart_emitter_buf #(.CLK_FREQ_HZ(25_000_000), .BAUD_RATE(57_600), .DEPTH(4),
                               .STOP_BITS(1), .ACT_HOLD(HOLD_A)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data_c), .i_valid(valid_c), .o_ready(ready_c),
    .o_uart_tx(tx_c), .o_level(level_c), .o_busy(busy_c), .o_activity(act_c));

  int cyc = 0;
  logic rst_s;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard and line monitor for dut_a.
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         mon_starts = 0;
  int         mon_frames = 0;
  int         last_start = 0;
  bit         mon_in = 0;
  int         fk = 0;
  logic       fbuf [FRAME_A];
  logic [7:0] got_b, exp_b;
  bit         shape_ok;

  always @(negedge clk) begin
    if (rst_s === 1'b1) begin
      mon_in = 0;
    end else if (!mon_in) begin
      if (tx_a === 1'b0) begin
        mon_in     = 1;
        fbuf[0]    = 1'b0;
        fk         = 1;
        last_start = cyc;
        mon_starts++;
      end
    end else begin
      fbuf[fk] = tx_a;
      fk++;
      if (fk == FRAME_A) begin
        mon_in   = 0;
        shape_ok = 1;
        for (int b = 0; b < 10; b++)
          for (int j = 0; j < DIV_A; j++)
            if (fbuf[b*DIV_A+j] !== fbuf[b*DIV_A+DIV_A/2]) shape_ok = 0;
        for (int b = 0; b < 8; b++) got_b[b] = fbuf[(b+1)*DIV_A + DIV_A/2];
        checks++;
        if (!shape_ok || fbuf[FRAME_A-1] !== 1'b1) begin
          errors++;
          $display("FAIL frame_shape @%0d: stop=%b uniform=%0d, required stop=1 uniform=1",
                   last_start, fbuf[FRAME_A-1], shape_ok);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame @%0d: got %02h, required no frame", last_start, got_b);
        end else begin
          exp_b = exp_q.pop_front();
          if (got_b !== exp_b) begin
            errors++;
            $display("FAIL byte_order @%0d: got %02h, required %02h", last_start, got_b, exp_b);
          end
        end
        start_q.push_back(last_start);
        mon_frames++;
      end
    end
  end

  // Expected line for up to two gapless frames starting at t=0.
  function automatic logic line_at(input logic [7:0] b0, input logic [7:0] b1,
                                   input int t, input int div, input int stops);
    int frame = (9 + stops) * div;
    int tt = t;
    logic [7:0] b = b0;
    int bitn;
    if (tt >= frame) begin
      tt = tt - frame;
      b  = b1;
    end
    bitn = tt / div;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge just after the acceptance edge.
  task automatic send_a(input logic [7:0] d, output int acc, output bit ok);
    int n = 0;
    valid_a = 1'b1;
    while (ready_a !== 1'b1 && n < 2000) begin
      data_a = 8'($urandom);
      @(negedge clk);
      n++;
    end
    ok     = (ready_a === 1'b1);
    data_a = d;
    acc    = cyc + 1;
    exp_q.push_back(d);
    @(negedge clk);
    valid_a = 1'b0;
    data_a  = 8'($urandom);
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (mon_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (mon_frames >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_a = 0; valid_b = 0; valid_c = 0;
    data_a = 0;  data_b = 0;  data_c = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready_a, ready_b, ready_c} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_low: got %b, required 000", {ready_a, ready_b, ready_c});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_a, tx_b, tx_c} !== 3'b111) begin
      errors++; $display("FAIL reset_tx: got %b, required 111", {tx_a, tx_b, tx_c});
    end
    checks++;
    if (level_a !== 0 || level_b !== 0 || level_c !== 0) begin
      errors++; $display("FAIL reset_level: got %0d/%0d/%0d, required 0", level_a, level_b, level_c);
    end
    checks++;
    if ({busy_a, busy_b, busy_c, act_a, act_b, act_c} !== 6'b0) begin
      errors++; $display("FAIL reset_busy_act: got %b, required 000000",
                         {busy_a, busy_b, busy_c, act_a, act_b, act_c});
    end
    checks++;
    if ({ready_a, ready_b, ready_c} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_after: got %b, required 111", {ready_a, ready_b, ready_c});
    end
  endtask

  task automatic test_single();
    int acc, fs;
    int busy_fall = -1, act_fall = -1;
    int n0 = mon_frames;
    bit ok;
    send_a(8'h55, acc, ok);
    checks++;
    if (!ok || level_a !== 3'd1) begin
      errors++; $display("FAIL single_level: got %0d, required 1", level_a);
    end
    for (int i = 0; i < 400; i++) begin
      if (busy_fall < 0 && busy_a === 1'b0) busy_fall = cyc;
      if (act_fall < 0 && busy_fall >= 0 && act_a === 1'b0) act_fall = cyc;
      if (act_fall >= 0 && mon_frames > n0) break;
      @(negedge clk);
    end
    checks++;
    if (mon_frames <= n0) begin
      errors++; $display("FAIL single_frame: got %0d frames, required 1", mon_frames - n0);
    end else begin
      fs = start_q[start_q.size()-1];
      checks++;
      if (fs - acc != 2) begin
        errors++; $display("FAIL single_latency: got %0d, required 2", fs - acc);
      end
      checks++;
      if (busy_fall != fs + FRAME_A - 1) begin
        errors++; $display("FAIL single_busy_fall: got %0d, required %0d", busy_fall, fs + FRAME_A - 1);
      end
      checks++;
      if (act_fall != busy_fall + HOLD_A) begin
        errors++; $display("FAIL single_act_fall: got %0d, required %0d", act_fall, busy_fall + HOLD_A);
      end
    end
  endtask

  task automatic test_burst();
    int idx = 0, guard = 0, n0 = mon_frames, s0 = start_q.size();
    bit saw_full = 0, ok;
    valid_a = 1'b1;
    while ((idx < 6 || mon_frames < n0 + 6) && guard < 1200) begin
      checks++;
      if (level_a > 3'd4) begin
        errors++; $display("FAIL burst_level_max: got %0d, required <=4", level_a);
      end
      checks++;
      if (ready_a !== (level_a != 3'd4)) begin
        errors++; $display("FAIL burst_ready: got %b at level %0d, required %b", ready_a, level_a, level_a != 3'd4);
      end
      if (level_a == 3'd4) saw_full = 1;
      if (idx < 6) begin
        data_a = 8'(idx);
        if (ready_a === 1'b1) begin
          exp_q.push_back(8'(idx));
          idx++;
        end
      end
      @(negedge clk);
      if (idx == 6) valid_a = 1'b0;
      guard++;
    end
    valid_a = 1'b0;
    wait_frames(n0 + 6, 10, ok);
    checks++;
    if (!ok || !saw_full) begin
      errors++; $display("FAIL burst_done: frames %0d full_seen %0d, required 6 and 1", mon_frames - n0, saw_full);
    end else begin
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (start_q[s0+k] - start_q[s0+k-1] != FRAME_A) begin
          errors++; $display("FAIL burst_gap%0d: got %0d, required %0d", k, start_q[s0+k] - start_q[s0+k-1], FRAME_A);
        end
      end
    end
  endtask

  task automatic test_push_pop_coincide();
    int acc, fs, k = 0, n0 = mon_frames, s0 = mon_starts, si = start_q.size();
    bit ok;
    logic [7:0] x = 8'($urandom), y = 8'($urandom), z = 8'($urandom);
    send_a(x, acc, ok);
    send_a(y, acc, ok);
    while (mon_starts == s0 && k < 20) begin @(negedge clk); k++; end
    fs = last_start;
    while (cyc < fs + FRAME_A - 2) @(negedge clk);
    checks++;
    if (level_a !== 3'd1 || ready_a !== 1'b1) begin
      errors++; $display("FAIL coincide_pre: level %0d ready %b, required 1 1", level_a, ready_a);
    end
    valid_a = 1'b1;
    data_a  = z;
    exp_q.push_back(z);
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if (level_a !== 3'd1) begin
      errors++; $display("FAIL coincide_level: got %0d, required 1", level_a);
    end
    wait_frames(n0 + 3, 400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL coincide_frames: got %0d, required 3", mon_frames - n0);
    end else begin
      checks++;
      if (start_q[si+2] - start_q[si] != 2 * FRAME_A) begin
        errors++; $display("FAIL coincide_gap: got %0d, required %0d", start_q[si+2] - start_q[si], 2 * FRAME_A);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, fs, k = 0, lows = 0, n1, s0 = mon_starts;
    bit ok;
    send_a(8'hA5, acc, ok);
    send_a(8'h11, acc, ok);
    send_a(8'h22, acc, ok);
    while (mon_starts == s0 && k < 20) begin @(negedge clk); k++; end
    fs = last_start;
    while (cyc < fs + 35) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready_during: got %b, required 0", ready_a);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tx_a !== 1'b1 || level_a !== 3'd0) begin
      errors++; $display("FAIL rstmid_state: tx %b level %0d, required 1 0", tx_a, level_a);
    end
    checks++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0 || act_a !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: ready %b busy %b act %b, required 1 0 0", ready_a, busy_a, act_a);
    end
    exp_q.delete();
    n1 = mon_starts;
    repeat (300) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || mon_starts != n1) begin
      errors++; $display("FAIL rstmid_quiet: got %0d low cycles, required 0", lows);
    end
    n1 = mon_frames;
    send_a(8'h3C, acc, ok);
    wait_frames(n1 + 1, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_fresh: got %0d frames, required 1", mon_frames - n1);
    end
  endtask

  task automatic test_random();
    int acc, n0 = mon_frames;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      send_a(8'($urandom), acc, ok);
      repeat ($urandom_range(0, 250)) @(negedge clk);
    end
    wait_frames(n0 + 8, 1200, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d frames, %0d pending, required 8 and 0", mon_frames - n0, exp_q.size());
    end
  endtask

  task automatic test_stop2();
    int acc, fs = -1, bad_t = -1;
    logic [7:0] r = 8'($urandom);
    logic bad_v = 1'b0;
    valid_b = 1'b1;
    data_b  = 8'hFF;
    checks++;
    if (ready_b !== 1'b1) begin
      errors++; $display("FAIL stop2_ready: got %b, required 1", ready_b);
    end
    acc = cyc + 1;
    @(negedge clk);
    data_b = r;
    @(negedge clk);
    valid_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_b === 1'b0) begin fs = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (fs - acc != 2) begin
      errors++; $display("FAIL stop2_latency: got %0d, required 2", fs - acc);
    end
    for (int t = 0; t < 220; t++) begin
      if (bad_t < 0 && tx_b !== line_at(8'hFF, r, t, DIV_A, 2)) begin
        bad_t = t; bad_v = tx_b;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_t >= 0) begin
      errors++; $display("FAIL stop2_wave: t=%0d got %b, required %b", bad_t, bad_v, ~bad_v);
    end
  endtask

  task automatic test_rounding();
    int fs = -1, bad_t = -1, t_rise = -1, t_fall = -1;
    logic prev = 1'b0, bad_v = 1'b0;
    logic [7:0] dec = 8'h00;
    valid_c = 1'b1;
    data_c  = 8'h0A;
    @(negedge clk);
    valid_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_c === 1'b0) begin fs = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (fs < 0) begin
      errors++; $display("FAIL round_start: no start bit, required one within 10 cycles");
    end
    for (int t = 0; t < 10 * DIV_C; t++) begin
      if (bad_t < 0 && tx_c !== line_at(8'h0A, 8'h00, t, DIV_C, 1)) begin
        bad_t = t; bad_v = tx_c;
      end
      if (t % DIV_C == DIV_C / 2 && t / DIV_C >= 1 && t / DIV_C <= 8) dec[t/DIV_C - 1] = tx_c;
      if (t > 0 && prev === 1'b0 && tx_c === 1'b1 && t_rise < 0) t_rise = t;
      if (t > 0 && prev === 1'b1 && tx_c === 1'b0 && t_rise >= 0 && t_fall < 0) t_fall = t;
      prev = tx_c;
      @(negedge clk);
    end
    checks++;
    if (t_fall - t_rise != DIV_C) begin
      errors++; $display("FAIL round_period: got %0d, required %0d", t_fall - t_rise, DIV_C);
    end
    checks++;
    if (dec !== 8'h0A) begin
      errors++; $display("FAIL round_decode: got %02h, required 0a", dec);
    end
    checks++;
    if (bad_t >= 0) begin
      errors++; $display("FAIL round_wave: t=%0d got %b, required %b", bad_t, bad_v, ~bad_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_push_pop_coincide();
    test_reset_mid();
    test_random();
    test_stop2();
    test_rounding();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
